// File: rtl/biquad_clip_monitor_if.sv
// Bus bundle for the biquad clip monitor. It carries the sample stream,
// the window controls and the per-window result outputs.
// aclk and aresetn stay plain ports on the module.
interface biquad_clip_monitor_if #(
    parameter int NSAMP   = 8,
    parameter int NBITS   = 12,
    parameter int CNTBITS = 24
);
    logic [NBITS*NSAMP-1:0] dat_i;
    logic                   enable_i;
    logic                   clear_i;
    logic [CNTBITS-1:0]     window_len_i;
    logic [CNTBITS-1:0]     clip_count_o;
    logic [NBITS-1:0]       peak_o;
    logic                   result_valid_o;

    // The side that drives samples and controls and receives results.
    modport master (
        output dat_i,
        output enable_i,
        output clear_i,
        output window_len_i,
        input  clip_count_o,
        input  peak_o,
        input  result_valid_o
    );

    // The monitor itself.
    modport slave (
        input  dat_i,
        input  enable_i,
        input  clear_i,
        input  window_len_i,
        output clip_count_o,
        output peak_o,
        output result_valid_o
    );
endinterface

// File: rtl/biquad_clip_monitor.sv
// Clip and peak monitor for a saturated multi-sample-per-clock filter output.
// Back-to-back windows of W clocks are measured. Each window reports how many
// samples sat on a rail and the largest magnitude seen.
// Pipeline:
//   edge 1 registers the vector with its first/last tags,
//   edge 2 forms the clip popcount and max magnitude,
//   edge 3 accumulates,
//   edge 4 publishes the result of a window whose last vector was accumulated.
module biquad_clip_monitor #(
    parameter int NSAMP   = 8,
    parameter int NBITS   = 12,
    parameter int CNTBITS = 24
) (
    input logic                  aclk,
    input logic                  aresetn,
    biquad_clip_monitor_if.slave bus
);

    localparam int PW = $clog2(NSAMP + 1);
    localparam int SW = ((CNTBITS > PW) ? CNTBITS : PW) + 1;

    localparam logic [NBITS-1:0]   POS_FULL = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0]   NEG_FULL = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0]   NB_ONE   = NBITS'(1);
    localparam logic [CNTBITS-1:0] CNT_ONE  = CNTBITS'(1);
    localparam logic [CNTBITS-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;

    // Window sequencing state: position inside the window and captured length.
    logic [CNTBITS-1:0] cyc_idx;
    logic [CNTBITS-1:0] win_len;

    logic [CNTBITS-1:0] cur_idx;
    logic [CNTBITS-1:0] eff_len;
    logic               tag_first;
    logic               tag_last;
    logic               sample_ok;

    // Stage 1 registers.
    logic [NBITS*NSAMP-1:0] s1_dat;
    logic                   s1_valid;
    logic                   s1_first;
    logic                   s1_last;

    // Stage 2 combinational results and registers.
    logic [NBITS-1:0] smp;
    logic [NBITS-1:0] mag;
    logic [PW-1:0]    pop_c;
    logic [NBITS-1:0] max_c;

    logic [PW-1:0]    s2_pop;
    logic [NBITS-1:0] s2_max;
    logic             s2_valid;
    logic             s2_first;
    logic             s2_last;

    // Stage 3 accumulators.
    logic [SW-1:0]      clip_base;
    logic [SW-1:0]      clip_sum;
    logic [CNTBITS-1:0] clip_next;
    logic [NBITS-1:0]   peak_next;

    logic [CNTBITS-1:0] acc_clip;
    logic [NBITS-1:0]   acc_peak;
    logic               s3_last;

    // Works out where the sample on this edge falls in its window.
    // A new window latches its length on cycle 0, with zero promoted to one.
    always_comb begin
        cur_idx   = (state == RUN) ? cyc_idx : '0;
        eff_len   = win_len;
        if (cur_idx == '0) begin
            eff_len = (bus.window_len_i == '0) ? CNT_ONE : bus.window_len_i;
        end
        tag_first = (cur_idx == '0);
        tag_last  = (cur_idx == (eff_len - CNT_ONE));
        sample_ok = bus.enable_i && !bus.clear_i;
    end

    // FSM plus stage 1: any edge with enable and no clear is a window cycle.
    // Anything else drops to IDLE and leaves the incoming vector untagged.
    // A partial window never carries a last tag, and the next first tag
    // restarts the accumulators. Its leftover vectors can never reach the
    // outputs, while a completed window already in flight still reports.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            cyc_idx  <= '0;
            win_len  <= '0;
            s1_dat   <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_dat <= bus.dat_i;
            if (sample_ok) begin
                state    <= RUN;
                s1_valid <= 1'b1;
                s1_first <= tag_first;
                s1_last  <= tag_last;
                if (tag_first) begin
                    win_len <= eff_len;
                end
                cyc_idx <= tag_last ? '0 : (cur_idx + CNT_ONE);
            end else begin
                state    <= IDLE;
                cyc_idx  <= '0;
                s1_valid <= 1'b0;
                s1_first <= 1'b0;
                s1_last  <= 1'b0;
            end
        end
    end

    // Per-sample rail detection and magnitude, reduced to a popcount and a max.
    // The magnitude is unsigned NBITS wide, so the negative rail maps to 2^(NBITS-1).
    always_comb begin
        smp   = '0;
        mag   = '0;
        pop_c = '0;
        max_c = '0;
        for (int k = 0; k < NSAMP; k++) begin
            smp = s1_dat[NBITS*k +: NBITS];
            mag = smp[NBITS-1] ? (~smp + NB_ONE) : smp;
            if ((smp == POS_FULL) || (smp == NEG_FULL)) begin
                pop_c = pop_c + PW'(1);
            end
            if (mag > max_c) begin
                max_c = mag;
            end
        end
    end

    // Stage 2 registers. A clear drops every tag so the aborted window vanishes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_pop   <= '0;
            s2_max   <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_pop <= pop_c;
            s2_max <= max_c;
            if (bus.clear_i) begin
                s2_valid <= 1'b0;
                s2_first <= 1'b0;
                s2_last  <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                s2_first <= s1_valid && s1_first;
                s2_last  <= s1_valid && s1_last;
            end
        end
    end

    // Next accumulator values. A first-tagged vector starts from zero.
    // The clip sum is formed one bit wider and pinned at the counter maximum.
    always_comb begin
        clip_base = s2_first ? '0 : SW'(acc_clip);
        clip_sum  = clip_base + SW'(s2_pop);
        clip_next = (clip_sum > SW'(CNT_MAX)) ? CNT_MAX : clip_sum[CNTBITS-1:0];
        peak_next = (s2_first || (s2_max > acc_peak)) ? s2_max : acc_peak;
    end

    // Stage 3 accumulation. The last tag travels along to trigger publishing.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_clip <= '0;
            acc_peak <= '0;
            s3_last  <= 1'b0;
        end else if (bus.clear_i) begin
            acc_clip <= '0;
            acc_peak <= '0;
            s3_last  <= 1'b0;
        end else if (s2_valid) begin
            acc_clip <= clip_next;
            acc_peak <= peak_next;
            s3_last  <= s2_last;
        end else begin
            s3_last  <= 1'b0;
        end
    end

    // Publish a finished window. The outputs hold across IDLE and clear,
    // and only reset zeroes them.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.clip_count_o   <= '0;
            bus.peak_o         <= '0;
            bus.result_valid_o <= 1'b0;
        end else begin
            bus.result_valid_o <= s3_last && !bus.clear_i;
            if (s3_last && !bus.clear_i) begin
                bus.clip_count_o <= acc_clip;
                bus.peak_o       <= acc_peak;
            end
        end
    end

endmodule

// File: tb/tb_biquad_clip_monitor.sv
// Scoreboard bench for biquad_clip_monitor.
// Two instances share clock, reset and stimulus: one uses the default 24-bit
// counter and one uses a 4-bit counter that saturates.
// Stimulus pushes a hand-computed result when it issues a window's last vector.
// A monitor pops and compares the entry whenever result_valid_o is seen.
module tb_biquad_clip_monitor;

    localparam int NSAMP = 8;
    localparam int NBITS = 12;

    typedef logic [NSAMP*NBITS-1:0] vec_t;

    typedef struct {
        int clip_a;
        int clip_b;
        int peak;
        int due;
    } exp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;

    biquad_clip_monitor_if #(.NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(24)) bus_a ();
    biquad_clip_monitor_if #(.NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(4))  bus_b ();

    biquad_clip_monitor #(.NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(24)) dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_a)
    );

    biquad_clip_monitor #(.NSAMP(NSAMP), .NBITS(NBITS), .CNTBITS(4)) dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_b)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   held_clip_a = 0;
    int   held_clip_b = 0;
    int   held_peak   = 0;
    vec_t v;

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic vec_t put(vec_t vin, int k, int val);
        vec_t vo;
        vo = vin;
        vo[NBITS*k +: NBITS] = NBITS'(val);
        return vo;
    endfunction

    function automatic vec_t fill_vec(int val);
        vec_t vo;
        vo = '0;
        for (int k = 0; k < NSAMP; k++) vo = put(vo, k, val);
        return vo;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one vector, sampled by both DUTs on the next rising edge.
    task automatic applyStimulus(input vec_t vin, input bit en, input bit clr, input int wlen);
        @(negedge aclk);
        bus_a.dat_i        = vin;
        bus_a.enable_i     = en;
        bus_a.clear_i      = clr;
        bus_a.window_len_i = 24'(wlen);
        bus_b.dat_i        = vin;
        bus_b.enable_i     = en;
        bus_b.clear_i      = clr;
        bus_b.window_len_i = 4'(wlen);
    endtask

    // Called right after the last vector of a window. The vector is sampled
    // at edge cyc+1 and the pulse is visible after edge cyc+4.
    task automatic expectResult(input int clip, input int peak);
        exp_t e;
        e.clip_a = clip;
        e.clip_b = (clip > 15) ? 15 : clip;
        e.peak   = peak;
        e.due    = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0, 0);
    endtask

    // Result monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge aclk);
            #2;
            if ((sb.size() > 0) && (cyc > sb[0].due)) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_pulse: no result_valid_o by cycle %0d, expected at cycle %0d", cyc, e.due);
            end
            if (bus_a.result_valid_o || bus_b.result_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: result_valid_o a=%0b b=%0b at cycle %0d, expected no pulse",
                             bus_a.result_valid_o, bus_b.result_valid_o, cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pulse_a", int'(bus_a.result_valid_o), 1);
                    checkOutput("pulse_b", int'(bus_b.result_valid_o), 1);
                    checkOutput("pulse_cycle", cyc, e.due);
                    checkOutput("clip_a", int'(bus_a.clip_count_o), e.clip_a);
                    checkOutput("clip_b", int'(bus_b.clip_count_o), e.clip_b);
                    checkOutput("peak_a", int'(bus_a.peak_o), e.peak);
                    checkOutput("peak_b", int'(bus_b.peak_o), e.peak);
                    held_clip_a = e.clip_a;
                    held_clip_b = e.clip_b;
                    held_peak   = e.peak;
                end
            end else begin
                checkOutput("hold_clip_a", int'(bus_a.clip_count_o), held_clip_a);
                checkOutput("hold_clip_b", int'(bus_b.clip_count_o), held_clip_b);
                checkOutput("hold_peak_a", int'(bus_a.peak_o), held_peak);
                checkOutput("hold_peak_b", int'(bus_b.peak_o), held_peak);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bus_a.dat_i = '0; bus_a.enable_i = 1'b0; bus_a.clear_i = 1'b0; bus_a.window_len_i = '0;
        bus_b.dat_i = '0; bus_b.enable_i = 1'b0; bus_b.clear_i = 1'b0; bus_b.window_len_i = '0;

        // Reset state.
        #1 aresetn = 1'b0;
        #1;
        checkOutput("reset_valid_a", int'(bus_a.result_valid_o), 0);
        checkOutput("reset_clip_a", int'(bus_a.clip_count_o), 0);
        checkOutput("reset_peak_a", int'(bus_a.peak_o), 0);
        checkOutput("reset_valid_b", int'(bus_b.result_valid_o), 0);
        checkOutput("reset_clip_b", int'(bus_b.clip_count_o), 0);
        checkOutput("reset_peak_b", int'(bus_b.peak_o), 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        idle(2);

        // W=4, one of each rail per vector: 8 clips, peak 2048.
        $display("[TB] window of 4 with both rails");
        v = put(put('0, 0, 2047), 1, -2048);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v, 1'b1, 1'b0, 4);
            if (i == 3) expectResult(8, 2048);
        end
        idle(6);

        // W=0 behaves as W=1: a result every clock.
        $display("[TB] zero window length");
        applyStimulus(put('0, 0, -5), 1'b1, 1'b0, 0);
        expectResult(0, 5);
        applyStimulus(put('0, 3, 100), 1'b1, 1'b0, 0);
        expectResult(0, 100);
        idle(6);

        // W=3 of all 2047: 24 clips, and the 4-bit counter pins at 15.
        $display("[TB] clip counter saturation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(fill_vec(2047), 1'b1, 1'b0, 3);
            if (i == 2) expectResult(24, 2047);
        end
        idle(6);

        // Back-to-back W=2 windows with distinct data.
        $display("[TB] back-to-back windows of 2");
        applyStimulus(put('0, 0, -2048), 1'b1, 1'b0, 2);
        applyStimulus('0, 1'b1, 1'b0, 2);
        expectResult(1, 2048);
        applyStimulus(put('0, 2, 300), 1'b1, 1'b0, 2);
        applyStimulus(put('0, 5, -301), 1'b1, 1'b0, 2);
        expectResult(0, 301);
        applyStimulus(put('0, 7, 2047), 1'b1, 1'b0, 2);
        applyStimulus(put('0, 7, -2047), 1'b1, 1'b0, 2);
        expectResult(1, 2047);
        idle(6);

        // W=10 with enable dropped on cycle 5: no result. Then a fresh W=2 window.
        $display("[TB] enable dropped mid-window");
        for (int i = 0; i < 5; i++) applyStimulus(fill_vec(2047), 1'b1, 1'b0, 10);
        applyStimulus(fill_vec(2047), 1'b0, 1'b0, 10);
        idle(6);
        applyStimulus(put('0, 1, 7), 1'b1, 1'b0, 2);
        applyStimulus(put('0, 2, -9), 1'b1, 1'b0, 2);
        expectResult(0, 9);
        idle(6);

        // Clear on the last cycle of a window wins. Then restart with W=1.
        $display("[TB] clear on window end");
        applyStimulus(put('0, 0, 2047), 1'b1, 1'b0, 3);
        applyStimulus('0, 1'b1, 1'b0, 3);
        applyStimulus('0, 1'b1, 1'b1, 3);
        idle(6);
        applyStimulus(put(put('0, 4, -1), 5, -2048), 1'b1, 1'b0, 1);
        expectResult(1, 2048);
        idle(6);

        // Reset pulsed mid-window: outputs zero and no pulse afterwards.
        $display("[TB] reset mid-window");
        applyStimulus(fill_vec(-2048), 1'b1, 1'b0, 4);
        applyStimulus(fill_vec(-2048), 1'b1, 1'b0, 4);
        @(negedge aclk);
        aresetn = 1'b0;
        held_clip_a = 0;
        held_clip_b = 0;
        held_peak   = 0;
        bus_a.enable_i = 1'b0;
        bus_b.enable_i = 1'b0;
        #1;
        checkOutput("midreset_valid_a", int'(bus_a.result_valid_o), 0);
        checkOutput("midreset_clip_a", int'(bus_a.clip_count_o), 0);
        checkOutput("midreset_peak_a", int'(bus_a.peak_o), 0);
        checkOutput("midreset_clip_b", int'(bus_b.clip_count_o), 0);
        checkOutput("midreset_peak_b", int'(bus_b.peak_o), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(8);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biquad_clip_monitor.md
BIQUAD_CLIP_MONITOR -- requirements
Module: biquad_clip_monitor

Interface
REQ-001 Parameter NSAMP, default 8: samples per clock on dat_i.
REQ-002 Parameter NBITS, default 12: signed sample width.
REQ-003 Parameter CNTBITS, default 24: width of the window length and the clip counter.
REQ-004 aclk  in  1: the only clock; all logic runs on its rising edge.
REQ-005 aresetn  in  1: asynchronous, active-low reset.
REQ-006 dat_i  in  NBITS*NSAMP: saturated filter output, sample k at [NBITS*k +: NBITS], two's complement, one new vector every clock.
REQ-007 enable_i  in  1: level; high runs back-to-back measurement windows.
REQ-008 clear_i  in  1: pulse; aborts the current window.
REQ-009 window_len_i  in  CNTBITS: window length in clocks.
REQ-010 clip_count_o  out  CNTBITS: number of clipped samples in the last completed window.
REQ-011 peak_o  out  NBITS: maximum |sample| in the last completed window, unsigned.
REQ-012 result_valid_o  out  1: one-cycle pulse when clip_count_o and peak_o update.

Function
REQ-013 A sample is clipped if it equals +(2^(NBITS-1)-1) or -2^(NBITS-1), i.e. 2047 or -2048 for NBITS=12.
REQ-014 |sample| is computed unsigned; |-2048| = 2048 and fits in NBITS bits.
REQ-015 The FSM has two states, IDLE and RUN.
REQ-016 IDLE->RUN occurs on the first edge at which enable_i=1 and clear_i=0; that edge is window cycle 0.
REQ-017 On cycle 0 of every window, window_len_i is captured; a captured value of 0 is treated as 1.
REQ-018 Each window comprises the dat_i vectors sampled on cycles 0..W-1.
REQ-019 On cycle W-1 the next window's cycle 0 is the following edge, with no gap, while enable_i=1.
REQ-020 Pipeline: edge 1 registers dat_i plus first/last window tags; edge 2 computes per-sample clip flags, their popcount, and a max-|x| tree; edge 3 accumulates.
REQ-021 result_valid_o pulses on the 3rd edge after the edge on which the window's last vector was sampled; outputs change only with that pulse.
REQ-022 The accumulator restarts on a first-tagged vector, so windows never mix.
REQ-023 The clip accumulator saturates at 2^CNTBITS-1 and never wraps.
REQ-024 Peak is the running maximum; ties leave it unchanged.
REQ-025 If enable_i falls in RUN, the FSM goes to IDLE on that edge and the partial window is discarded: tags in flight are cleared and no result_valid_o is produced.
REQ-026 If clear_i=1 in any state, the FSM goes to IDLE, the pipeline tags and accumulators clear, and no result_valid_o is produced for the aborted window.
REQ-027 If clear_i and a window end coincide, clear wins.
REQ-028 A cleared or disabled block restarts per REQ-016 on the next qualifying edge.
REQ-029 clip_count_o and peak_o hold their last values across IDLE and clear; only reset zeroes them.

Reset
REQ-030 On aresetn=0, immediately and asynchronously: FSM=IDLE, all pipeline registers and tags 0, accumulators 0, clip_count_o=0, peak_o=0, result_valid_o=0.
REQ-031 The FSM leaves IDLE no earlier than the first rising aclk edge after aresetn deasserts.
REQ-032 Reset asserted mid-window discards that window; no result_valid_o is produced for it.

Verification
REQ-033 NSAMP=8, W=4, dat_i all 0 except one 2047 and one -2048 per cycle -> result_valid_o pulses 3 clocks after window end, clip_count_o=8, peak_o=2048.
REQ-034 W=0 and enable_i held high, with samples -5 on cycle A and 100 on cycle B -> result_valid_o pulses every clock, and the results are peak_o=5 and then peak_o=100 for consecutive windows.
REQ-035 CNTBITS=4, W=3, all samples 2047 -> clip_count_o=15, saturated, not 24 mod 16.
REQ-036 W=10, enable_i dropped on cycle 5 -> no result_valid_o, outputs unchanged; re-enable -> next result reflects only new data.
REQ-037 clear_i asserted on a window's last cycle -> no result_valid_o for that window; aresetn pulsed mid-window -> all outputs 0 and no pulse.
REQ-038 Back-to-back W=2 windows with different data -> results do not mix; pulses are exactly 2 clocks apart.
